// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences CSRRW/RS/RC (and immediate forms) as read-modify-write on the CSR file
module csr_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_rs1_i,
   input  logic [4:0]        req_zimm_i,
   input  logic              req_rs1_nz_i,
   input  logic              req_rd_nz_i,
   input  logic              flush_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_illegal_o,
   output logic              csr_en_o,
   output logic              csr_we_o,
   output logic [ADDR_W-1:0] csr_addr_o,
   output logic [DATA_W-1:0] csr_data_o,
   input  logic [DATA_W-1:0] csr_data_i,
   input  logic              csr_busy_i,
   input  logic              csr_exists_i,
   input  logic              csr_ro_i
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] src_q, old_q, wdata;
   logic              src_nz_q, rd_nz_q, illegal_q, seen_busy_q, wr_issued_q;
   logic              accept, bad_f3, is_rw, do_read, do_write, illegal_acc, done;
   assign accept      = state_q == IDLE && req_valid_i && !flush_i;
   assign bad_f3      = req_funct3_i[1:0] == 2'b00;
   assign is_rw       = op_q == 2'b01;
   assign do_read     = !(is_rw && !rd_nz_q);
   assign do_write    = is_rw || src_nz_q;
   assign illegal_acc = !csr_exists_i || (do_write && (csr_ro_i || addr_q[ADDR_W-1 -: 2] == 2'b11));
   assign done        = seen_busy_q && !csr_busy_i;
   assign wdata       = is_rw ? src_q : (op_q == 2'b10) ? (old_q | src_q) : (old_q & ~src_q);
   // state register
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   // next state and CSR/response strobes; strobes only fire when the file is idle
   always_comb begin
      state_d       = state_q;
      req_ready_o   = 1'b0;
      csr_en_o      = 1'b0;
      csr_we_o      = 1'b0;
      csr_addr_o    = '0;
      csr_data_o    = '0;
      rsp_valid_o   = 1'b0;
      rsp_data_o    = '0;
      rsp_illegal_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = !flush_i;
            if (accept) state_d = bad_f3 ? RESP : RD_REQ;
         end
         RD_REQ: begin
            csr_addr_o = addr_q;
            if (flush_i)          state_d = IDLE;
            else if (illegal_acc) state_d = RESP;
            else if (!do_read)    state_d = WR_REQ;
            else if (!csr_busy_i) begin
               csr_en_o = 1'b1;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            csr_addr_o = addr_q;
            if (flush_i)   state_d = IDLE;
            else if (done) state_d = do_write ? WR_REQ : RESP;
         end
         WR_REQ: begin
            csr_addr_o = addr_q;
            if (!csr_busy_i) begin
               csr_en_o   = 1'b1;
               csr_we_o   = 1'b1;
               csr_data_o = wdata;
               state_d    = WR_WAIT;
            end
         end
         WR_WAIT: begin
            csr_addr_o = addr_q;
            if (done) state_d = RESP;
         end
         RESP: begin
            csr_addr_o    = addr_q;
            rsp_valid_o   = 1'b1;
            rsp_data_o    = old_q;
            rsp_illegal_o = illegal_q;
            if ((flush_i && !wr_issued_q) || rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // latched request, old value, busy rise/fall tracking and write-issued marker
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         op_q        <= '0;
         addr_q      <= '0;
         src_q       <= '0;
         old_q       <= '0;
         src_nz_q    <= 1'b0;
         rd_nz_q     <= 1'b0;
         illegal_q   <= 1'b0;
         seen_busy_q <= 1'b0;
         wr_issued_q <= 1'b0;
      end else begin
         if (accept) begin
            op_q        <= req_funct3_i[1:0];
            addr_q      <= req_addr_i;
            src_q       <= req_funct3_i[2] ? {{(DATA_W-5){1'b0}}, req_zimm_i} : req_rs1_i;
            src_nz_q    <= req_funct3_i[2] ? |req_zimm_i : req_rs1_nz_i;
            rd_nz_q     <= req_rd_nz_i;
            old_q       <= '0;
            illegal_q   <= bad_f3;
            wr_issued_q <= 1'b0;
         end
         if (state_q == RD_REQ && !flush_i && illegal_acc) illegal_q <= 1'b1;
         if (state_q == RD_WAIT && done) old_q <= csr_data_i;
         if (state_q == WR_REQ && !csr_busy_i) wr_issued_q <= 1'b1;
         seen_busy_q <= (state_q == RD_WAIT || state_q == WR_WAIT) && (seen_busy_q || csr_busy_i) && !done;
      end
endmodule
